// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, axis state encoding,
// RGB332 field positions and the RGB332 -> 8:8:8 channel expansion helper.
package vga_timing_pkg;

  // Horizontal timing in pixels, vertical timing in lines.
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int CNT_W  = 10;

  // RGB332 field positions
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {AX_ACT, AX_FP, AX_SYNC, AX_BP} axis_state_e;

  // Raw per-pixel timing flags, all active-high.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } timing_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication maps full-scale 3/2-bit codes to exactly 8'hFF.
  function automatic rgb888_t expand332(input logic [7:0] c);
    rgb888_t o;
    o.r = {c[R_MSB:R_LSB], c[R_MSB:R_LSB], c[R_MSB -: 2]};
    o.g = {c[G_MSB:G_LSB], c[G_MSB:G_LSB], c[G_MSB -: 2]};
    o.b = {4{c[B_MSB:B_LSB]}};
    return o;
  endfunction

endpackage

// File: rtl/vga_pixel_scanner_if.sv
// vga_pixel_scanner_if: scanner <-> sprite lookup / game logic / DAC bundle.
//   master (scanner): drives scan coordinates, sync/blank/colour pins, frame_tick;
//                     receives bg_color and the registered sprite lookup result.
//   slave  (consumer): the opposite directions.
interface vga_pixel_scanner_if;
  import vga_timing_pkg::*;

  logic [7:0]       bg_color;
  logic [7:0]       sprite_data;
  logic             sprite_visible;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             vga_hs;
  logic             vga_vs;
  logic             vga_blank_n;
  logic [7:0]       vga_r;
  logic [7:0]       vga_g;
  logic [7:0]       vga_b;
  logic             frame_tick;

  modport master (
    input  bg_color, sprite_data, sprite_visible,
    output pixel_x, pixel_y, vga_hs, vga_vs, vga_blank_n,
           vga_r, vga_g, vga_b, frame_tick
  );

  modport slave (
    output bg_color, sprite_data, sprite_visible,
    input  pixel_x, pixel_y, vga_hs, vga_vs, vga_blank_n,
           vga_r, vga_g, vga_b, frame_tick
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis (H or V). Counts 0..VIS+FP+SYNC+BP-1 on i_ce
// and tracks the ACT -> FP -> SYNC -> BP region as a registered state.
//   clk, rst_n : clock, async active-low reset
//   i_ce       : advance enable
//   o_count    : current position
//   o_state    : region of o_count
//   o_wrap     : high on the enabled cycle where the count returns to 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS  = H_VIS,
  parameter int FP   = H_FP,
  parameter int SYNC = H_SYNC,
  parameter int BP   = H_BP
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ce,
  output logic [CNT_W-1:0] o_count,
  output axis_state_e      o_state,
  output logic             o_wrap
);
  localparam int TOTAL = VIS + FP + SYNC + BP;

  logic [CNT_W-1:0] r_count;
  axis_state_e      r_state;
  logic             w_last;

  assign w_last  = (r_count == CNT_W'(TOTAL - 1));
  // Combinational so the next axis advances on the same enable as this wrap.
  assign o_wrap  = i_ce & w_last;
  assign o_count = r_count;
  assign o_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_state <= AX_ACT;
    end else if (i_ce) begin
      if (w_last) begin
        r_count <= '0;
        r_state <= AX_ACT;
      end else begin
        r_count <= r_count + 1'b1;
        unique case (r_state)
          AX_ACT:  if (r_count == CNT_W'(VIS - 1))             r_state <= AX_FP;
          AX_FP:   if (r_count == CNT_W'(VIS + FP - 1))        r_state <= AX_SYNC;
          AX_SYNC: if (r_count == CNT_W'(VIS + FP + SYNC - 1)) r_state <= AX_BP;
          AX_BP:   r_state <= AX_BP;
          default: r_state <= AX_ACT;
        endcase
      end
    end
  end
endmodule

// File: rtl/vga_pixel_scanner.sv
// vga_pixel_scanner: VGA timing generator and sprite compositor.
//   clk, rst_n : system clock, async active-low reset
//   bus        : vga_pixel_scanner_if.master
//     in : bg_color, sprite_data, sprite_visible (registered sprite lookup result,
//          SPRITE_LAT pixels behind pixel_x/pixel_y)
//     out: pixel_x/pixel_y scan counters, vga_hs/vga_vs (active-low), vga_blank_n,
//          vga_r/g/b, frame_tick (one clk at entry to vertical blanking)
// Timing parameters default to 640x480@60; they exist so shorter frames can be built.
module vga_pixel_scanner
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int SPRITE_LAT = 1,
  parameter int P_H_VIS    = H_VIS,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_VIS    = V_VIS,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
)(
  input logic                 clk,
  input logic                 rst_n,
  vga_pixel_scanner_if.master bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // ---- pixel clock enable: last clk of each CLK_DIV group ----
  logic [DIV_W-1:0] r_div;
  logic             w_pix_ce;

  assign w_pix_ce = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_div <= '0;
    else if (w_pix_ce) r_div <= '0;
    else               r_div <= r_div + 1'b1;
  end

  // ---- scan counters ----
  logic [CNT_W-1:0] w_h_count, w_v_count;
  axis_state_e      w_h_state, w_v_state;
  logic             w_h_wrap, w_v_wrap_unused;

  vga_axis_counter #(.VIS(P_H_VIS), .FP(P_H_FP), .SYNC(P_H_SYNC), .BP(P_H_BP)) u_h (
    .clk(clk), .rst_n(rst_n), .i_ce(w_pix_ce),
    .o_count(w_h_count), .o_state(w_h_state), .o_wrap(w_h_wrap)
  );

  vga_axis_counter #(.VIS(P_V_VIS), .FP(P_V_FP), .SYNC(P_V_SYNC), .BP(P_V_BP)) u_v (
    .clk(clk), .rst_n(rst_n), .i_ce(w_h_wrap),
    .o_count(w_v_count), .o_state(w_v_state), .o_wrap(w_v_wrap_unused)
  );

  assign bus.pixel_x = w_h_count;
  assign bus.pixel_y = w_v_count;

  // ---- raw timing, delayed to line up with the sprite lookup result ----
  timing_t                  w_raw, w_dly;
  timing_t [SPRITE_LAT-1:0] r_dly;

  assign w_raw.hs  = (w_h_state == AX_SYNC);
  assign w_raw.vs  = (w_v_state == AX_SYNC);
  assign w_raw.act = (w_h_state == AX_ACT) && (w_v_state == AX_ACT);
  assign w_dly     = r_dly[SPRITE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly <= '0;
    end else if (w_pix_ce) begin
      r_dly[0] <= w_raw;
      for (int i = 1; i < SPRITE_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // ---- compositor + output register ----
  // sprite_visible alone selects the sprite; blanking forces black regardless.
  logic [7:0] w_pix332;
  rgb888_t    w_rgb, r_rgb;
  logic       r_hs, r_vs, r_blank_n, r_tick;

  assign w_pix332 = bus.sprite_visible ? bus.sprite_data : bus.bg_color;
  assign w_rgb    = w_dly.act ? expand332(w_pix332) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (w_pix_ce) begin
      r_hs      <= ~w_dly.hs;
      r_vs      <= ~w_dly.vs;
      r_blank_n <= w_dly.act;
      r_rgb     <= w_rgb;
    end
  end

  // Fires on the edge the counters step into (0, P_V_VIS); updates every clk
  // so the pulse is a single clk wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick <= 1'b0;
    else        r_tick <= w_h_wrap && (w_v_count == CNT_W'(P_V_VIS - 1));
  end

  assign bus.vga_hs      = r_hs;
  assign bus.vga_vs      = r_vs;
  assign bus.vga_blank_n = r_blank_n;
  assign bus.vga_r       = r_rgb.r;
  assign bus.vga_g       = r_rgb.g;
  assign bus.vga_b       = r_rgb.b;
  assign bus.frame_tick  = r_tick;
endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Bench for vga_pixel_scanner: full-width lines, vertical timing shortened to
// 13 lines so whole frames fit in a short run.
module tb_vga_pixel_scanner;
  localparam int CD  = 2;
  localparam int HT  = 800;
  localparam int HV  = 640;
  localparam int HF  = 16;
  localparam int HS  = 96;
  localparam int VV  = 6;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VT  = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  vga_pixel_scanner_if bus();

  vga_pixel_scanner #(
    .CLK_DIV(CD), .SPRITE_LAT(1),
    .P_V_VIS(VV), .P_V_FP(VF), .P_V_SYNC(VS), .P_V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, bl;
    logic [7:0] r, g, b;
    logic tick;
  } obs_t;

  int n_chk = 0;
  int n_fail = 0;
  int mode = 0;
  int unsigned seed = 0;
  bit chk_en = 0;
  bit rand_bg = 0;

  // ---- sprite lookup stand-in: two clk register stages behind the scan ----
  function automatic logic [8:0] sprite_of(input int m, input int x, input int y,
                                            input int unsigned s);
    logic [31:0] h;
    if (m == 0) begin
      if (x >= 100 && x <= 109) return {1'b1, 8'hE0};
      if (x >= HV)              return {1'b1, 8'hFF};
      return 9'h000;
    end
    h = (32'(x) * 32'h9E3779B1) ^ (32'(y) * 32'h85EBCA77) ^ s;
    h = h ^ (h >> 15);
    return h[8:0];
  endfunction

  logic [8:0] s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= sprite_of(mode, int'(bus.pixel_x), int'(bus.pixel_y), seed);
    s2 <= s1;
  end
  assign bus.sprite_visible = s2[8];
  assign bus.sprite_data    = s2[7:0];

  always @(negedge clk) begin
    #3;
    if (!rand_bg)                          bus.bg_color = 8'h03;
    else if ($urandom_range(0, 7) == 0)    bus.bg_color = 8'($urandom);
  end

  // ---- reference model: clk edges since reset release, bg at last pixel edge ----
  int m_n = 0;
  logic [7:0] m_bg = 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_n <= 0;
    else begin
      if ((m_n + 1) % CD == 0) m_bg <= bus.bg_color;
      m_n <= m_n + 1;
    end
  end

  // Pins show the pixel two pixel periods behind the counters.
  function automatic obs_t expect_at(input int n, input logic [7:0] bg);
    obs_t e;
    int p, q, qx, qy;
    logic [8:0] sp;
    logic [7:0] c;
    e = '0;
    p = n / CD;
    e.x = 10'(p % HT);
    e.y = 10'((p / HT) % VT);
    e.tick = (n > 0) && (n % CD == 0) && (p % FRAME == VV * HT);
    q = p - 2;
    if (q < 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      q  = q % FRAME;
      qx = q % HT;
      qy = q / HT;
      e.hs = !(qx >= HV + HF && qx < HV + HF + HS);
      e.vs = !(qy >= VV + VF && qy < VV + VF + VS);
      e.bl = (qx < HV) && (qy < VV);
      if (e.bl) begin
        sp = sprite_of(mode, qx, qy, seed);
        c  = sp[8] ? sp[7:0] : bg;
        e.r = 8'(int'(c[7:5]) * 36 + int'(c[7:5]) / 2);
        e.g = 8'(int'(c[4:2]) * 36 + int'(c[4:2]) / 2);
        e.b = 8'(int'(c[1:0]) * 85);
      end
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.x = bus.pixel_x;  o.y = bus.pixel_y;
    o.hs = bus.vga_hs;  o.vs = bus.vga_vs;  o.bl = bus.vga_blank_n;
    o.r = bus.vga_r;    o.g = bus.vga_g;    o.b = bus.vga_b;
    o.tick = bus.frame_tick;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      obs_t a, e;
      a = observe();
      e = expect_at(m_n, m_bg);
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scan n=%0d: got %h expected %h", m_n, a, e);
      end
    end
  end

  task automatic wait_tick(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Row-0 pixels, bg=8'h03; sprite E0 on x=100..109 and FF across horizontal blanking.
  typedef struct {
    int x;
    logic [7:0] r, g, b;
    logic bl, hs;
  } vec_t;
  vec_t tbl[12];

  initial begin
    obs_t rst_obs;
    int g, t0, lowcnt, vs_low;
    bit ok;

    tbl[0]  = '{99,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b1};
    tbl[1]  = '{100, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[2]  = '{105, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[3]  = '{109, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[4]  = '{110, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1};
    tbl[5]  = '{639, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1};
    tbl[6]  = '{640, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{655, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{656, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{751, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{752, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{799, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};

    mode = 0;
    seed = $urandom;
    rst_obs = '0;
    rst_obs.hs = 1'b1;
    rst_obs.vs = 1'b1;
    chk_en = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_hold", observe(), rst_obs);
    #2 rst_n = 1'b1;

    // compositing / blank override / sync edges within the first line
    for (int i = 0; i < 12; i++) begin
      g = 0;
      while (m_n < CD * (tbl[i].x + 2) && g < 5000) begin
        @(negedge clk);
        g++;
      end
      check($sformatf("vec_x%0d", tbl[i].x),
            {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_blank_n, bus.vga_hs},
            {tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].bl, tbl[i].hs});
    end

    // line timing on line 1
    g = 0;
    while (!(bus.vga_hs == 1'b0 && m_n > CD * HT) && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check("hs_first_low", m_n, CD * (HT + HV + HF + 2));
    t0 = m_n;
    lowcnt = 0;
    while (bus.vga_hs == 1'b0 && lowcnt < 4000) begin
      lowcnt++;
      @(negedge clk);
    end
    check("hs_low_clk", lowcnt, CD * HS);
    g = 0;
    while (bus.vga_hs != 1'b0 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check("line_period", m_n - t0, CD * HT);

    // frame timing
    wait_tick(25000, ok);
    check("tick1_seen", ok, 1);
    check("tick1_time", m_n, CD * VV * HT);
    t0 = m_n;
    vs_low = 0;
    ok = 1'b0;
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (!bus.vga_vs) vs_low++;
      if (bus.frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    check("tick2_seen", ok, 1);
    check("frame_period", m_n - t0, CD * FRAME);
    check("vs_low_clk", vs_low, CD * VS * HT);

    // mid-frame reset at (321, 2), then random sprites and background
    g = 0;
    while (m_n != CD * (2 * FRAME + 2 * HT + 321) && g < 30000) begin
      @(negedge clk);
      g++;
    end
    check("pre_reset_xy", {bus.pixel_y, bus.pixel_x}, {10'd2, 10'd321});
    #2 rst_n = 1'b0;
    mode = 1;
    rand_bg = 1'b1;
    #1 check("async_reset", observe(), rst_obs);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_tick(25000, ok);
    check("tick_after_reset_seen", ok, 1);
    check("tick_after_reset_time", m_n, CD * VV * HT);
    repeat (3000) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
